fast_corner_collector: RTL and testbench
========================================

Name: fast_corner_collector

Overview:
- Sink end of the FAST_with_NMS output interface (iscorner, x_coord, y_coord).
- Captures each detected corner as a {y,x} record and buffers records in a FIFO.
- Drains records over a valid/ready stream and closes every frame with a trailer word carrying the corner count.
- Replaces the file-logging bench consumer in hardware, so corners can feed a DMA or descriptor stage.

Parameters:
- COL_NUM, 640, image width in pixels.
- ROW_NUM, 480, image height in pixels.
- COORD_WIDTH, 10, width of x_coord and y_coord.
- FIFO_DEPTH, 64, record FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- iscorner  in  1  corner strobe from FAST_with_NMS, sampled every cycle.
- x_coord  in  COORD_WIDTH  column of the current NMS output pixel; free-running.
- y_coord  in  COORD_WIDTH  row of the current NMS output pixel; free-running.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  2*COORD_WIDTH  record {y,x}, or trailer count (zero-extended).
- m_last  out  1  1 = trailer word, closes the frame.
- overflow  out  1  sticky flag: at least one corner dropped in the current frame.
- drop_count  out  16  corners dropped in the current frame; saturating.

Interface note: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
- Reset (asynchronous, active-high, effective at any time including mid-frame and mid-transfer):
  - FIFO emptied; trailer_pending cleared.
  - m_valid=0, m_data=0, m_last=0, overflow=0, drop_count=0, corner count=0.
  - prev_last register = 1, so the coordinates present at reset release do not register as a frame end.
- Capture: on any clk edge where iscorner=1, the record {y_coord,x_coord} with last=0 is written if the FIFO is not full.
- Corner counter (width 2*COORD_WIDTH):
  - Increments on every corner, whether written or dropped.
  - Saturates at all-ones.
- Frame end:
  - fe = (x_coord==COL_NUM-1) && (y_coord==ROW_NUM-1) && !prev_last.
  - prev_last tracks the last-pixel compare every cycle, so repeated last-pixel coordinates do not retrigger.
  - On fe, trailer_pending is set. The count snapshot includes a corner at the last pixel in the same cycle.
  - The corner counter, overflow and drop_count are cleared on the cycle after the snapshot.
- Write arbitration, at most one FIFO write per cycle:
  - Priority 1: pending trailer {count, last=1}.
  - Priority 2: corner record.
  - A corner and fe in the same cycle: the corner is written that cycle; the trailer is written next cycle.
  - A corner colliding with a pending trailer, or arriving while the FIFO is full, is dropped: overflow<=1, drop_count+1, saturating at 16'hFFFF.
  - The trailer is never dropped; it stays pending until the FIFO has space.
- Output is a first-word-fall-through FIFO with registered output:
  - m_valid rises on the edge after the write edge (1-cycle latency into an empty FIFO).
  - A transfer occurs when m_valid && m_ready.
  - m_data and m_last are held stable while m_valid && !m_ready.
  - Full throughput: one word per cycle when m_ready stays high.
- Simultaneous read and write at full: both succeed and occupancy is unchanged, so a corner arriving in that cycle is NOT dropped.
- Empty with m_ready=1: no transfer, m_valid stays 0.
- Ordering: records appear in arrival order, followed by their frame's trailer. Records of frame N+1 never precede trailer N.

Decomposition:
- fast_pkg:
  - COORD_WIDTH constant.
  - typedef corner_rec_t packed {logic last; logic [COORD_WIDTH-1:0] y, x;}.
  - Trailer encoding helper.
- Sub-module corner_fifo: synchronous FWFT FIFO.
  - Parameterised by width and depth.
  - Asynchronous active-high rst.
  - Ports: wr_en, din, full, rd_en, dout, empty.
  - Pointers are log2(DEPTH)+1 bits; full/empty decided by MSB comparison.
- Top level holds the frame-end detector, counters, arbitration and trailer register.

Test Plan (COL_NUM=8, ROW_NUM=4, FIFO_DEPTH=4 unless noted):
- Basic frame: corners at (x=2,y=1) and (x=5,y=2), coordinates stepping through all 32 positions, m_ready=1 -> words 0x0402(?) as {y=1,x=2}, then {y=2,x=5}, then trailer m_last=1 with m_data=2; overflow=0.
- Last-pixel corner: iscorner=1 at (7,3) -> record {3,7} emitted, then trailer with m_data=1 on the following word; no drop.
- Backpressure overflow: m_ready=0, 6 corners in one frame -> 4 stored, overflow=1, drop_count=2. Release m_ready -> 4 records, then trailer m_data=6 (written once space frees). Next frame: overflow=0.
- Stall stability: m_ready toggles 1010… -> each word is held until accepted; no duplicates; order preserved.
- Reset mid-frame: 3 corners buffered, rst pulsed asynchronously between clock edges -> m_valid=0 immediately, FIFO empty. Next full frame yields only its own corners plus a correct trailer count.
- Held coordinates: x_coord=7, y_coord=3 held for 5 cycles -> exactly one trailer emitted.

Source files
------------

// File: rtl/fast_pkg.sv
// Shared types and helpers for the FAST corner collector: the record layout
// and the packing of the frame trailer word.
package fast_pkg;

    localparam int COORD_WIDTH = 10;
    localparam int COUNT_WIDTH = 2 * COORD_WIDTH;

    typedef struct packed {
        logic                   last;
        logic [COORD_WIDTH-1:0] y;
        logic [COORD_WIDTH-1:0] x;
    } corner_rec_t;

    localparam int REC_WIDTH = $bits(corner_rec_t);

    function automatic corner_rec_t make_record(input logic [COORD_WIDTH-1:0] y,
                                                input logic [COORD_WIDTH-1:0] x);
        corner_rec_t rec;
        rec.last = 1'b0;
        rec.y    = y;
        rec.x    = x;
        return rec;
    endfunction

    // The count spans the y/x fields, so {y,x} of a trailer reads back as the count.
    function automatic corner_rec_t make_trailer(input logic [COUNT_WIDTH-1:0] count);
        corner_rec_t rec;
        rec.last = 1'b1;
        rec.y    = count[COUNT_WIDTH-1:COORD_WIDTH];
        rec.x    = count[COORD_WIDTH-1:0];
        return rec;
    endfunction

endpackage

// File: rtl/fast_corner_collector_fifo.sv
// First-word-fall-through FIFO with a registered output word; the head entry
// stays in storage until it is popped, so capacity is exactly DEPTH.
module corner_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             do_rd, do_wr;

    // A write into a full FIFO is accepted when the head is popped in the same cycle.
    assign do_rd = rd_en && valid_q;
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
        valid_d  = (rd_ptr_d != wr_ptr_q);
        dout_d   = valid_d ? mem_q[rd_ptr_d[AW-1:0]] : dout_q;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            dout_q   <= dout_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout  = dout_q;
    assign empty = !valid_q;

endmodule

// File: rtl/fast_corner_collector.sv
// Collects FAST_with_NMS corner strobes into {y,x} records, streams them out
// over valid/ready and closes every frame with a trailer carrying the corner count.
module fast_corner_collector
    import fast_pkg::*;
#(
    parameter int COL_NUM    = 640,
    parameter int ROW_NUM    = 480,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iscorner,
    input  logic [COORD_WIDTH-1:0]   x_coord,
    input  logic [COORD_WIDTH-1:0]   y_coord,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [2*COORD_WIDTH-1:0] m_data,
    output logic                     m_last,
    output logic                     overflow,
    output logic [15:0]              drop_count
);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic                   prev_last_q, prev_last_d;
    logic                   trl_pend_q, trl_pend_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d, count_inc;
    logic [COUNT_WIDTH-1:0] trl_count_q, trl_count_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            drop_q, drop_d;
    logic                   last_px, fe, space, wr_trl, wr_rec, drop;
    logic                   fifo_wr, fifo_full, fifo_empty;
    corner_rec_t            fifo_din, fifo_dout;

    assign last_px = (x_coord == COORD_WIDTH'(COL_NUM - 1)) &&
                     (y_coord == COORD_WIDTH'(ROW_NUM - 1));

    // NOTE: every combinational result gets a default first so no path infers a latch.
    always_comb begin
        prev_last_d = last_px;
        fe          = last_px && !prev_last_q;
        space       = !fifo_full || (m_valid && m_ready);
        wr_trl      = trl_pend_q && space;
        wr_rec      = iscorner && !trl_pend_q && space;
        drop        = iscorner && !wr_rec;
        count_inc   = (iscorner && count_q != COUNT_MAX) ? count_q + 1'b1 : count_q;
        fifo_wr     = wr_trl || wr_rec;
        fifo_din    = wr_trl ? make_trailer(trl_count_q) : make_record(y_coord, x_coord);
        trl_pend_d  = fe || (trl_pend_q && !wr_trl);
        trl_count_d = trl_count_q;
        count_d     = count_inc;
        overflow_d  = overflow_q || drop;
        drop_d      = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        // The snapshot includes a corner on the last pixel; the new frame starts from zero.
        if (fe) begin
            trl_count_d = count_inc;
            count_d     = '0;
            overflow_d  = 1'b0;
            drop_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_last_q <= 1'b1;
            trl_pend_q  <= 1'b0;
            count_q     <= '0;
            trl_count_q <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            prev_last_q <= prev_last_d;
            trl_pend_q  <= trl_pend_d;
            count_q     <= count_d;
            trl_count_q <= trl_count_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
        end
    end

    corner_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (fifo_wr),
        .din   (fifo_din),
        .full  (fifo_full),
        .rd_en (m_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign m_valid    = !fifo_empty;
    assign m_data     = {fifo_dout.y, fifo_dout.x};
    assign m_last     = fifo_dout.last;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_fast_corner_collector.sv
// Randomized bench for fast_corner_collector on an 8x4 image with a 4-entry FIFO,
// checked cycle by cycle against a queue-based model of the output stream.
module tb_fast_corner_collector;
    import fast_pkg::*;

    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iscorner = 1'b0;
    logic [9:0]  x_coord = '0;
    logic [9:0]  y_coord = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [19:0] m_data;
    logic        m_last;
    logic        overflow;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    fast_corner_collector #(
        .COL_NUM    (COLS),
        .ROW_NUM    (ROWS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iscorner   (iscorner),
        .x_coord    (x_coord),
        .y_coord    (y_coord),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Model: words waiting for downstream, stamped with the edge that wrote them.
    typedef struct {
        logic [19:0] word;
        bit          last;
        longint      wedge;
    } exp_t;

    exp_t        mq[$];
    logic [20:0] log_q[$];
    longint      edge_n = 0;
    int unsigned m_count, m_trl_count, m_drops;
    bit          m_prev_last, m_pend, m_ovf;

    function automatic bit model_valid();
        return (mq.size() > 0) && (mq[0].wedge < edge_n);
    endfunction

    function automatic logic [20:0] obs(input int i);
        return (i < log_q.size()) ? log_q[i] : 21'bx;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_count = 0; m_trl_count = 0; m_drops = 0;
        m_prev_last = 1'b1; m_pend = 1'b0; m_ovf = 1'b0;
    endtask

    // One clock: compare outputs against the model, drive inputs, advance the model.
    task automatic cycle(input bit c, input int x, input int y, input bit r);
        bit mv, pop, space, last, fe, wr_trl, wr_rec, drop;
        int unsigned inc;
        exp_t e;
        @(negedge clk);
        mv = model_valid();
        checks++;
        if (m_valid !== mv) begin
            errors++;
            $display("FAIL m_valid t=%0t got %b want %b", $time, m_valid, mv);
        end
        if (mv) begin
            checks++;
            if ({m_last, m_data} !== {mq[0].last, mq[0].word}) begin
                errors++;
                $display("FAIL word t=%0t got last=%b data=%h want last=%b data=%h",
                         $time, m_last, m_data, mq[0].last, mq[0].word);
            end
        end
        checks++;
        if (overflow !== m_ovf || drop_count !== 16'(m_drops)) begin
            errors++;
            $display("FAIL drop_state t=%0t got ovf=%b drops=%0d want ovf=%b drops=%0d",
                     $time, overflow, drop_count, m_ovf, m_drops);
        end
        iscorner = c;
        x_coord  = 10'(x);
        y_coord  = 10'(y);
        m_ready  = r;
        if (m_valid === 1'b1 && r) log_q.push_back({m_last, m_data});
        @(posedge clk);
        pop    = mv && r;
        space  = (mq.size() < DEPTH) || pop;
        last   = (x == COLS - 1) && (y == ROWS - 1);
        fe     = last && !m_prev_last;
        m_prev_last = last;
        wr_trl = m_pend && space;
        wr_rec = c && !m_pend && space;
        drop   = c && !wr_rec;
        inc    = (c && m_count != 32'hFFFFF) ? m_count + 1 : m_count;
        if (pop) void'(mq.pop_front());
        if (wr_trl || wr_rec) begin
            e.word  = wr_trl ? m_trl_count[19:0] : 20'((y << 10) | x);
            e.last  = wr_trl;
            e.wedge = edge_n + 1;
            mq.push_back(e);
        end
        if (fe) begin
            m_trl_count = inc;
            m_pend = 1'b1; m_count = 0; m_ovf = 1'b0; m_drops = 0;
        end else begin
            m_pend  = m_pend && !wr_trl;
            m_count = inc;
            m_ovf   = m_ovf || drop;
            if (drop && m_drops != 16'hFFFF) m_drops++;
        end
        edge_n++;
    endtask

    // rmode: 0 ready high, 1 ready low, 2 toggling 1010..., 3 random
    task automatic run_pos(input bit [31:0] mask, input int p, input int rmode);
        bit r;
        case (rmode)
            0:       r = 1'b1;
            1:       r = 1'b0;
            2:       r = (p % 2 == 0);
            default: r = 1'($urandom_range(0, 1));
        endcase
        cycle(mask[p], p % COLS, p / COLS, r);
    endtask

    task automatic run_frame(input bit [31:0] mask, input int rmode);
        for (int p = 0; p < COLS * ROWS; p++) run_pos(mask, p, rmode);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 20'd0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_stream got valid=%b data=%h last=%b want 0 0 0", m_valid, m_data, m_last);
        end
        checks++;
        if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop got ovf=%b drops=%0d want 0 0", overflow, drop_count);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drain(3);
    endtask

    task automatic test_basic_frame();
        bit [31:0]   mask;
        logic [20:0] exp_w [3];
        log_q.delete();
        mask = '0;
        mask[1*COLS+2] = 1'b1;
        mask[2*COLS+5] = 1'b1;
        exp_w = '{{1'b0, 20'h00402}, {1'b0, 20'h00805}, {1'b1, 20'd2}};
        run_frame(mask, 0);
        drain(6);
        checks++;
        if (log_q.size() != 3) begin
            errors++;
            $display("FAIL basic_len got %0d want 3", log_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== exp_w[i]) begin
                errors++;
                $display("FAIL basic_word%0d got %h want %h", i, obs(i), exp_w[i]);
            end
        end
    endtask

    task automatic test_last_pixel();
        bit [31:0] mask;
        log_q.delete();
        mask = '0;
        mask[31] = 1'b1;
        run_frame(mask, 0);
        drain(6);
        checks++;
        if (log_q.size() != 2 || obs(0) !== {1'b0, 20'h00C07} || obs(1) !== {1'b1, 20'd1}) begin
            errors++;
            $display("FAIL last_pixel got n=%0d %h %h want n=2 00c07 100001", log_q.size(), obs(0), obs(1));
        end
    endtask

    task automatic test_overflow();
        bit [31:0] mask;
        log_q.delete();
        mask = 32'h0000_0AAA;
        for (int p = 0; p < COLS * ROWS; p++) begin
            run_pos(mask, p, 1);
            if (p == 20) begin
                #1;
                checks++;
                if (overflow !== 1'b1 || drop_count !== 16'd2) begin
                    errors++;
                    $display("FAIL ovf_flag got ovf=%b drops=%0d want 1 2", overflow, drop_count);
                end
            end
        end
        drain(10);
        checks++;
        if (log_q.size() != 5 || obs(0) !== 21'h00001 || obs(1) !== 21'h00003 ||
            obs(2) !== 21'h00005 || obs(3) !== 21'h00007 || obs(4) !== {1'b1, 20'd6}) begin
            errors++;
            $display("FAIL ovf_drain got n=%0d %h %h %h %h %h want n=5 1 3 5 7 trailer 6",
                     log_q.size(), obs(0), obs(1), obs(2), obs(3), obs(4));
        end
        log_q.delete();
        for (int p = 0; p < COLS * ROWS; p++) begin
            run_pos('0, p, 0);
            if (p == 5) begin
                #1;
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_next_frame got %b want 0", overflow);
                end
            end
        end
        drain(6);
        checks++;
        if (log_q.size() != 1 || obs(0) !== {1'b1, 20'd0}) begin
            errors++;
            $display("FAIL empty_frame got n=%0d %h want n=1 100000", log_q.size(), obs(0));
        end
    endtask

    task automatic test_stall();
        bit [31:0]   mask;
        logic [20:0] exp_w[$];
        int          mism;
        log_q.delete();
        mask = '0;
        for (int p = 0; p < COLS * ROWS - 1; p += 3) begin
            mask[p] = 1'($urandom_range(0, 1));
            if (mask[p]) exp_w.push_back({1'b0, 20'(((p / COLS) << 10) | (p % COLS))});
        end
        exp_w.push_back({1'b1, 20'($countones(mask))});
        run_frame(mask, 2);
        drain(12);
        mism = 0;
        for (int i = 0; i < exp_w.size(); i++) if (obs(i) !== exp_w[i]) mism++;
        checks++;
        if (log_q.size() != exp_w.size() || mism != 0) begin
            errors++;
            $display("FAIL stall_order got n=%0d bad=%0d want n=%0d bad=0", log_q.size(), mism, exp_w.size());
        end
    endtask

    task automatic test_reset_mid();
        bit [31:0] mask;
        mask = 32'h0000_0054;
        for (int p = 0; p < 9; p++) run_pos(mask, p, 1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 20'd0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_async got valid=%b data=%h ovf=%b drops=%0d want 0 0 0 0",
                     m_valid, m_data, overflow, drop_count);
        end
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        log_q.delete();
        mask = $urandom;
        run_frame(mask, 0);
        drain(8);
        checks++;
        if (log_q.size() != $countones(mask) + 1 ||
            obs(log_q.size() - 1) !== {1'b1, 20'($countones(mask))}) begin
            errors++;
            $display("FAIL reset_frame got n=%0d tail=%h want n=%0d tail count %0d",
                     log_q.size(), obs(log_q.size() - 1), $countones(mask) + 1, $countones(mask));
        end
    endtask

    task automatic test_held_last();
        int trailers;
        log_q.delete();
        for (int i = 0; i < 5; i++) cycle(1'b0, COLS - 1, ROWS - 1, 1'b1);
        drain(6);
        trailers = 0;
        foreach (log_q[i]) if (log_q[i][20]) trailers++;
        checks++;
        if (trailers != 1 || log_q.size() != 1) begin
            errors++;
            $display("FAIL held_last got trailers=%0d words=%0d want 1 1", trailers, log_q.size());
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            run_frame($urandom, 3);
            drain(16);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_last_pixel();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_held_last();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
